// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: widths,
// step count, FSM state and operation encodings.
package mul_div_seq_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned STEPS = 16;
  localparam int unsigned CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/mul_div_step_ctr.sv
// Step counter for the iterative datapath; tc flags the last step.
module mul_div_step_ctr
  import mul_div_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(STEPS - 1));

endmodule

// File: rtl/mul_div_seq.sv
// Radix-2 shift-add multiplier / restoring divider, one bit per cycle,
// using an external shared 16-bit add/sub unit.
module mul_div_seq
  import mul_div_seq_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  output logic             ADD_CTRL,
  input  logic [WIDTH-1:0] ADD_S,
  input  logic             ADD_COUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0,
  output logic [WIDTH-1:0] RES_HI,
  output logic [WIDTH-1:0] RES_LO
);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic             div0_q;

  logic             accept, div_by_zero, is_div_in;
  logic             step_tc;
  logic [CNT_W-1:0] step_cnt;

  logic [WIDTH-1:0] shift_in, mul_sum, step_hi, step_lo;
  logic             mul_c;

  assign is_div_in   = (op_t'(OP) == OP_DIV);
  assign accept      = (state_q == ST_IDLE) && START;
  assign div_by_zero = is_div_in && (OPB == '0);

  mul_div_step_ctr u_step_ctr (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (accept),
    .en    (state_q == ST_RUN),
    .cnt   (step_cnt),
    .tc    (step_tc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (START) state_d = div_by_zero ? ST_FIN : ST_RUN;
      ST_RUN:  if (step_tc) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration per RUN cycle; the adder result arrives combinationally.
  always_comb begin
    ADD_A    = '0;
    ADD_B    = '0;
    ADD_CTRL = 1'b0;
    shift_in = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    mul_c    = 1'b0;
    mul_sum  = hi_q;
    step_hi  = hi_q;
    step_lo  = lo_q;
    if (state_q == ST_RUN) begin
      ADD_B = opnd_q;
      if (op_q == OP_MUL) begin
        ADD_A = hi_q;
        if (lo_q[0]) {mul_c, mul_sum} = {ADD_COUT, ADD_S};
        step_hi = {mul_c, mul_sum[WIDTH-1:1]};
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else begin
        ADD_A    = shift_in;
        ADD_CTRL = 1'b1;
        // hi_q[15] is the bit shifted out of T: the 17-bit remainder always covers D.
        if (hi_q[WIDTH-1] | ADD_COUT) begin
          step_hi = ADD_S;
          step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          step_hi = shift_in;
          step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div0_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op_t'(OP);
      div0_q <= div_by_zero;
      opnd_q <= is_div_in ? OPB : OPA;
      if (div_by_zero) begin
        hi_q <= OPA;
        lo_q <= '1;
      end else begin
        hi_q <= '0;
        lo_q <= is_div_in ? OPA : OPB;
      end
    end else if (state_q == ST_RUN) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);
  assign DIV0   = div0_q;
  assign RES_HI = hi_q;
  assign RES_LO = lo_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_mul_div_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        OP = 1'b0;
  logic [15:0] OPA = '0, OPB = '0;
  logic [15:0] ADD_A, ADD_B, ADD_S, RES_HI, RES_LO;
  logic        ADD_CTRL, ADD_COUT, BUSY, DONE, DIV0;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Shared add/sub unit: subtract is A + ~B + 1, carry-out meaning A >= B.
  logic [16:0] add_full;
  assign add_full = ADD_CTRL ? ({1'b0, ADD_A} + {1'b0, ~ADD_B} + 17'd1)
                             : ({1'b0, ADD_A} + {1'b0, ADD_B});
  assign ADD_S    = add_full[15:0];
  assign ADD_COUT = add_full[16];

  mul_div_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CTRL(ADD_CTRL), .ADD_S(ADD_S),
    .ADD_COUT(ADD_COUT), .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0),
    .RES_HI(RES_HI), .RES_LO(RES_LO)
  );

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  // Returns {div0, hi, lo}
  function automatic logic [32:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (!op) begin
      p = 32'(a) * 32'(b);
      return {1'b0, p};
    end
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    return {1'b0, a % b, a / b};
  endfunction

  // Entered at a negedge; returns at the negedge where DONE is seen (or bound expires).
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input int inject, output int lat, output logic busy_seen,
                        output logic add_bad);
    START = 1'b1; OP = op; OPA = a; OPB = b;
    lat = 0; busy_seen = 1'b0; add_bad = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
      START = 1'b0;
      if (lat == inject) begin
        START = 1'b1; OP = 1'b1; OPA = 16'hBEEF; OPB = 16'h0000;
      end
      if (BUSY) begin
        busy_seen = 1'b1;
        if (ADD_CTRL !== op) add_bad = 1'b1;
      end else if (ADD_A !== 16'h0 || ADD_B !== 16'h0 || ADD_CTRL !== 1'b0) begin
        add_bad = 1'b1;
      end
    end while (DONE !== 1'b1 && lat < 40);
    START = 1'b0;
  endtask

  typedef struct {
    logic        op;
    logic [15:0] a, b, hi, lo;
    logic        div0;
    int          lat;
  } vec_t;

  vec_t        vecs[12];
  int          lat;
  logic        busy_seen, add_bad, done_seen;
  logic [32:0] m;
  logic [15:0] ra, rb;
  logic        rop;

  initial begin
    vecs[0]  = '{1'b0, 16'h0005, 16'h0003, 16'h0000, 16'h000F, 1'b0, 17};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
    vecs[2]  = '{1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 17};
    vecs[3]  = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[4]  = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};
    vecs[5]  = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[6]  = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17};
    vecs[7]  = '{1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17};
    vecs[8]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 17};
    vecs[10] = '{1'b1, 16'h8000, 16'h8001, 16'h8000, 16'h0000, 1'b0, 17};
    vecs[11] = '{1'b1, 16'hFFFE, 16'h8001, 16'h7FFD, 16'h0001, 1'b0, 17};

    // Reset state
    #2;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_div0", 32'(DIV0), 32'd0);
    check("rst_res", {RES_HI, RES_LO}, 32'h0);
    check("rst_add", {15'h0, ADD_CTRL, ADD_A | ADD_B}, 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    @(negedge CLK);

    // Directed table; each op starts in the first IDLE cycle after the previous FIN
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, busy_seen, add_bad);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_hi", i), 32'(RES_HI), 32'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 32'(RES_LO), 32'(vecs[i].lo));
      check($sformatf("vec%0d_div0", i), 32'(DIV0), 32'(vecs[i].div0));
      check($sformatf("vec%0d_busy", i), 32'(busy_seen), 32'(!vecs[i].div0));
      check($sformatf("vec%0d_add", i), 32'(add_bad), 32'd0);
      @(negedge CLK);
      check($sformatf("vec%0d_pulse", i), 32'(DONE), 32'd0);
      check($sformatf("vec%0d_hold", i), {RES_HI, RES_LO}, {vecs[i].hi, vecs[i].lo});
    end

    // START during FIN is ignored
    run_op(1'b0, 16'h0002, 16'h0004, 0, lat, busy_seen, add_bad);
    START = 1'b1; OP = 1'b1; OPA = 16'h7777; OPB = 16'h0000;
    @(negedge CLK);
    START = 1'b0;
    check("fin_start_busy", 32'(BUSY), 32'd0);
    check("fin_start_done", 32'(DONE), 32'd0);
    check("fin_start_res", {15'h0, DIV0, RES_LO}, 32'h0008);

    // START at RUN step 5 with new operands is ignored
    run_op(1'b0, 16'h0005, 16'h0003, 6, lat, busy_seen, add_bad);
    check("inj_lat", 32'(lat), 32'd17);
    check("inj_res", {15'h0, DIV0, RES_HI, RES_LO} , 32'h0000000F);
    @(negedge CLK);

    // Reset at RUN step 8 aborts without DONE
    START = 1'b1; OP = 1'b0; OPA = 16'h1234; OPB = 16'h5678;
    repeat (9) begin @(negedge CLK); START = 1'b0; end
    check("abort_pre_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_res", {RES_HI, RES_LO}, 32'h0);
    check("abort_add", {15'h0, ADD_CTRL, ADD_A | ADD_B}, 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    done_seen = 1'b0;
    repeat (20) begin @(negedge CLK); if (DONE) done_seen = 1'b1; end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op(1'b0, 16'h0002, 16'h0003, 0, lat, busy_seen, add_bad);
    check("post_rst_lat", 32'(lat), 32'd17);
    check("post_rst_res", {RES_HI, RES_LO}, 32'h00000006);
    @(negedge CLK);

    // Random operations against the arithmetic model
    for (int i = 0; i < 200; i++) begin
      rop = 1'($urandom);
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom >> ($urandom_range(0, 3) * 4));
      m   = model(rop, ra, rb);
      run_op(rop, ra, rb, 0, lat, busy_seen, add_bad);
      check($sformatf("rnd%0d_lat op=%0d %h,%h", i, rop, ra, rb), 32'(lat), m[32] ? 32'd1 : 32'd17);
      check($sformatf("rnd%0d_res op=%0d %h,%h", i, rop, ra, rb), {RES_HI, RES_LO}, m[31:0]);
      check($sformatf("rnd%0d_div0", i), 32'(DIV0), 32'(m[32]));
      check($sformatf("rnd%0d_add", i), 32'(add_bad), 32'd0);
      @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising-edge.
REQ-002 SHALL have: RST_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: START  in  1  one-cycle request, sampled only in IDLE.
REQ-004 SHALL have: OP  in  1  0=unsigned multiply, 1=unsigned divide; sampled with START.
REQ-005 SHALL have: OPA, OPB  in  16 each  multiplicand/dividend (OPA) and multiplier/divisor (OPB).
REQ-006 SHALL have: ADD_A, ADD_B  out  16 each  operands driven to the shared 16-bit add/sub unit.
REQ-007 SHALL have: ADD_CTRL  out  1  0=add, 1=subtract (A-B, two's complement), to shared unit.
REQ-008 SHALL have: ADD_S  in  16, ADD_COUT  in  1  combinational result/carry from the shared unit, same cycle.
REQ-009 SHALL have: BUSY  out  1, DONE  out  1  one-cycle pulse, DIV0  out  1  divide-by-zero flag.
REQ-010 SHALL have: RES_HI, RES_LO  out  16 each  product {HI,LO}, or remainder (HI) / quotient (LO).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIN; a 4-bit step counter counts 0..15 in RUN.
REQ-012 IDLE & START & !(OP & OPB==0): load operands, clear HI and counter, enter RUN next edge.
REQ-013 IDLE & START & OP & OPB==0: enter FIN directly; RES_LO=FFFF, RES_HI=OPA, DIV0=1.
REQ-014 START outside IDLE SHALL be ignored with no effect on state or results.
REQ-015 Multiply step: ADD_A=HI, ADD_B=M, ADD_CTRL=0; if LO[0], {C,HI}={ADD_COUT,ADD_S}, else C=0; then {C,HI,LO} shifts right 1.
REQ-016 Divide step: T={HI[14:0],LO[15]}; ADD_A=T, ADD_B=D, ADD_CTRL=1; if HI[15] | ADD_COUT then HI=ADD_S, LO={LO[14:0],1}, else HI=T, LO={LO[14:0],0}.
REQ-017 RUN SHALL last exactly 16 cycles; after step 15 enter FIN; FIN lasts 1 cycle then IDLE.
REQ-018 Latency: START at edge N -> DONE high in cycle after edge N+17 (N+1 for divide-by-zero).
REQ-019 BUSY=1 exactly while in RUN; DONE=1 exactly while in FIN.
REQ-020 RES_HI/RES_LO/DIV0 SHALL hold final values from FIN until next accepted START; DIV0 cleared on accepted START.
REQ-021 Outside RUN, ADD_A/ADD_B SHALL be 0000 and ADD_CTRL 0.
REQ-022 START in the FIN cycle SHALL be ignored; START in the first IDLE cycle after FIN SHALL be accepted.
REQ-023 Results SHALL be mathematically exact for all 16-bit unsigned operands (product modulo 2^32 not needed).

Reset
REQ-024 RST_N low SHALL immediately force IDLE, counter 0, BUSY=0, DONE=0, DIV0=0, RES_HI=RES_LO=0000, ADD_* =0.
REQ-025 Reset asserted mid-operation SHALL abort it with no DONE pulse; first START after release behaves normally.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, OP encodings, STEPS=16, width WIDTH=16.
REQ-027 Sole natural sub-module: mul_div_step_ctr (4-bit step counter with terminal-count flag); the adder stays external and shared.

Verification
REQ-028 MUL 0005*0003 -> DONE at START+17, RES_HI=0000, RES_LO=000F, DIV0=0.
REQ-029 MUL FFFF*FFFF -> RES_HI=FFFE, RES_LO=0001; ADD_CTRL=0 every RUN cycle.
REQ-030 DIV 0064/0007 -> RES_LO=000E, RES_HI=0002; DIV FFFF/0001 -> RES_LO=FFFF, RES_HI=0000.
REQ-031 DIV 1234/0000 -> DONE at START+1, DIV0=1, RES_LO=FFFF, RES_HI=1234, BUSY never high.
REQ-032 START pulsed at RUN step 5 with new operands -> ignored; original result and 17-cycle latency unchanged.
REQ-033 RST_N low at RUN step 8 -> outputs zero at once, no DONE; next MUL 0002*0003 -> RES_LO=0006.
